vfm_ifetch: RTL and testbench

- Instruction fetch stage of the VFM core, directly upstream of the CU/IR path.
- Owns the PC and issues requests to program memory over a req/ack handshake.
- Buffers returned 14-bit instruction words (IW) in a 2-entry prefetch queue and presents IR to the CU, and to the debug disassembler.
- Inserts the STALL word 14'h3FFF whenever no valid IW is available.
- Honours CU redirects (JUMP/CALL/RET targets) by flushing the queue and squashing in-flight fetches.

---
 rtl/vfm_pkg.sv | 16 +
 rtl/vfm_ifetch_q.sv | 56 +++++
 rtl/vfm_ifetch.sv | 164 ++++++++++++++++
 tb/tb_vfm_ifetch.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vfm_pkg.sv
// Shared VFM core definitions: default widths, the STALL instruction word and
// the fetch FSM state encoding.
package vfm_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_IW_W   = 14;

  localparam logic [13:0] STALL_IW = 14'h3FFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/vfm_ifetch_q.sv
// Two-entry prefetch FIFO of {IW, PC} pairs with push, pop, flush and an
// occupancy count; the head entry is visible combinationally.
module vfm_ifetch_q #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IW_W   = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [IW_W-1:0]   i_iw,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [IW_W-1:0]   o_head_iw,
  output logic [ADDR_W-1:0] o_head_pc,
  output logic [1:0]        o_count
);

  logic [IW_W-1:0]   r_iw [2];
  logic [ADDR_W-1:0] r_pc [2];
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_count;

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iw[0] <= '0;
      r_iw[1] <= '0;
      r_pc[0] <= '0;
      r_pc[1] <= '0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_iw[r_wr] <= i_iw;
        r_pc[r_wr] <= i_pc;
        r_wr       <= ~r_wr;
      end
      if (i_pop) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_head_iw = r_iw[r_rd];
  assign o_head_pc = r_pc[r_rd];
  assign o_count   = r_count;

endmodule

// File: rtl/vfm_ifetch.sv
// VFM instruction fetch stage: PC, program-memory req/ack FSM, prefetch queue
// and IR presentation. Optional perf counters under VFM_IFETCH_PERF_EN.
module vfm_ifetch #(
  parameter int unsigned        ADDR_W   = vfm_pkg::DEF_ADDR_W,
  parameter int unsigned        IW_W     = vfm_pkg::DEF_IW_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              Clk_pin,
  input  logic              Reset_pin,
  output logic              Pm_req,
  output logic [ADDR_W-1:0] Pm_addr,
  input  logic              Pm_ack,
  input  logic [IW_W-1:0]   Pm_data,
  output logic [IW_W-1:0]   IR,
  output logic [ADDR_W-1:0] IR_pc,
  output logic              IR_valid,
  input  logic              IR_take,
  input  logic              Redir,
  input  logic [ADDR_W-1:0] Redir_pc,
  input  logic              Hold
`ifdef VFM_IFETCH_PERF_EN
  ,
  output logic [15:0]       Fetch_cnt,
  output logic [15:0]       Stall_cnt
`endif
);

  import vfm_pkg::*;

  localparam logic [IW_W-1:0] STALL_WORD = IW_W'(STALL_IW);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_last_pc;

  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_valid;
  logic [1:0]        w_count;
  logic [2:0]        w_cnt_after;
  logic [ADDR_W-1:0] w_pc_next;
  logic [IW_W-1:0]   w_head_iw;
  logic [ADDR_W-1:0] w_head_pc;

  assign w_valid     = (w_count != 2'd0);
  assign w_pop       = IR_take & w_valid;
  assign w_push      = (r_state == S_REQ) & Pm_ack & ~Redir;
  assign w_cnt_after = 3'(w_count) + 3'(w_push) - 3'(w_pop);

  // PC advances on every kept fetch; a redirect overrides it.
  always_comb begin
    w_pc_next = r_pc;
    if (Redir) begin
      w_pc_next = Redir_pc;
    end else if (w_push) begin
      w_pc_next = r_pc + ADDR_W'(1);
    end
  end

  // Fetch FSM: at most one request outstanding, space reserved for it.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!Hold && (Redir || (w_count != 2'd2))) begin
          w_issue = 1'b1;
        end
      end
      S_REQ: begin
        if (Pm_ack) begin
          if (!Hold && (Redir || (w_cnt_after < 3'd2))) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (Redir) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (Pm_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_issue) begin
      w_state_nxt = S_REQ;
    end
  end

  always_ff @(posedge Clk_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
      r_pc      <= RESET_PC;
      r_last_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt != S_IDLE);
      r_pc    <= w_pc_next;
      if (w_issue) begin
        r_addr <= w_pc_next;
      end
      if (w_valid) begin
        r_last_pc <= w_head_pc;
      end
    end
  end

  vfm_ifetch_q #(
    .ADDR_W (ADDR_W),
    .IW_W   (IW_W)
  ) u_q (
    .i_clk     (Clk_pin),
    .i_rst     (Reset_pin),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (Redir),
    .i_iw      (Pm_data),
    .i_pc      (r_addr),
    .o_head_iw (w_head_iw),
    .o_head_pc (w_head_pc),
    .o_count   (w_count)
  );

  assign Pm_req   = r_req;
  assign Pm_addr  = r_addr;
  assign IR_valid = w_valid;
  assign IR       = w_valid ? w_head_iw : STALL_WORD;
  assign IR_pc    = w_valid ? w_head_pc : r_last_pc;

`ifdef VFM_IFETCH_PERF_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating counters; squashed fetches never reach w_push.
  always_ff @(posedge Clk_pin or posedge Reset_pin) begin
    if (Reset_pin) begin
      r_fetch_cnt <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      if (w_push && (r_fetch_cnt != 16'hFFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
      if (!w_valid && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign Fetch_cnt = r_fetch_cnt;
  assign Stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_vfm_ifetch.sv
// Directed, table-driven bench for vfm_ifetch: streaming, back-pressure,
// redirects, PC wrap, Hold and asynchronous reset.
module tb_vfm_ifetch;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned IW_W   = 14;
  localparam int unsigned NVEC   = 32;

  logic              clk;
  logic              rst;
  logic              pm_req;
  logic [ADDR_W-1:0] pm_addr;
  logic              pm_ack;
  logic [IW_W-1:0]   pm_data;
  logic [IW_W-1:0]   ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              ir_take;
  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              hold;
`ifdef VFM_IFETCH_PERF_EN
  logic [15:0]       fetch_cnt;
  logic [15:0]       stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vfm_ifetch dut (
    .Clk_pin   (clk),
    .Reset_pin (rst),
    .Pm_req    (pm_req),
    .Pm_addr   (pm_addr),
    .Pm_ack    (pm_ack),
    .Pm_data   (pm_data),
    .IR        (ir),
    .IR_pc     (ir_pc),
    .IR_valid  (ir_valid),
    .IR_take   (ir_take),
    .Redir     (redir),
    .Redir_pc  (redir_pc),
    .Hold      (hold)
`ifdef VFM_IFETCH_PERF_EN
    ,
    .Fetch_cnt (fetch_cnt),
    .Stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              ack;
    logic [ADDR_W-1:0] daddr;
    logic              take;
    logic              hld;
    logic              rdr;
    logic [ADDR_W-1:0] rpc;
    logic              e_req;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
  } vec_t;

  vec_t tbl [NVEC];

  // Memory content is a function of the address so IR identifies its source.
  function automatic logic [IW_W-1:0] iw_of(input logic [ADDR_W-1:0] a);
    return 14'h1000 | IW_W'(a);
  endfunction

  function automatic vec_t mk(input logic ack, input int daddr, input logic take,
                              input logic hld, input logic rdr, input int rpc,
                              input logic e_req, input int e_addr,
                              input logic e_valid, input int e_pc);
    vec_t v;
    v.ack = ack;   v.daddr = ADDR_W'(daddr); v.take = take; v.hld = hld;
    v.rdr = rdr;   v.rpc = ADDR_W'(rpc);     v.e_req = e_req;
    v.e_addr = ADDR_W'(e_addr); v.e_valid = e_valid; v.e_pc = ADDR_W'(e_pc);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic e_req, input logic [ADDR_W-1:0] e_addr,
                               input logic e_valid, input logic [ADDR_W-1:0] e_pc);
    logic [IW_W-1:0] e_ir;
    e_ir = e_valid ? iw_of(e_pc) : 14'h3FFF;
    chk("Pm_req",   idx, 32'(pm_req),   32'(e_req));
    chk("Pm_addr",  idx, 32'(pm_addr),  32'(e_addr));
    chk("IR_valid", idx, 32'(ir_valid), 32'(e_valid));
    chk("IR",       idx, 32'(ir),       32'(e_ir));
    chk("IR_pc",    idx, 32'(ir_pc),    32'(e_pc));
  endtask

  task automatic apply(input vec_t v);
    pm_ack   = v.ack;
    pm_data  = v.ack ? iw_of(v.daddr) : '0;
    ir_take  = v.take;
    hold     = v.hld;
    redir    = v.rdr;
    redir_pc = v.rpc;
  endtask

  initial begin
    //            ack daddr take hld rdr rpc     req addr   val pc
    tbl[0]  = mk(0, 0,     1,   0,  0,  0,      0,  0,     0,  0);
    tbl[1]  = mk(1, 0,     1,   0,  0,  0,      1,  0,     0,  0);
    tbl[2]  = mk(1, 1,     1,   0,  0,  0,      1,  1,     1,  0);
    tbl[3]  = mk(1, 2,     1,   0,  0,  0,      1,  2,     1,  1);
    tbl[4]  = mk(1, 3,     1,   0,  0,  0,      1,  3,     1,  2);
    tbl[5]  = mk(0, 0,     0,   0,  0,  0,      1,  4,     1,  3);
    tbl[6]  = mk(1, 4,     0,   0,  0,  0,      1,  4,     1,  3);
    tbl[7]  = mk(0, 0,     0,   0,  0,  0,      0,  4,     1,  3);
    tbl[8]  = mk(0, 0,     0,   0,  0,  0,      0,  4,     1,  3);
    tbl[9]  = mk(0, 0,     0,   0,  0,  0,      0,  4,     1,  3);
    tbl[10] = mk(0, 0,     0,   0,  0,  0,      0,  4,     1,  3);
    tbl[11] = mk(0, 0,     1,   0,  0,  0,      0,  4,     1,  3);
    tbl[12] = mk(0, 0,     1,   0,  0,  0,      0,  4,     1,  4);
    tbl[13] = mk(0, 0,     1,   0,  0,  0,      1,  5,     0,  4);
    tbl[14] = mk(1, 5,     1,   0,  0,  0,      1,  5,     0,  4);
    tbl[15] = mk(0, 0,     0,   0,  0,  0,      1,  6,     1,  5);
    tbl[16] = mk(0, 0,     0,   0,  1,  'h2A,   1,  6,     1,  5);
    tbl[17] = mk(0, 0,     0,   0,  0,  0,      1,  6,     0,  5);
    tbl[18] = mk(0, 0,     0,   0,  0,  0,      1,  6,     0,  5);
    tbl[19] = mk(1, 6,     0,   0,  0,  0,      1,  6,     0,  5);
    tbl[20] = mk(0, 0,     0,   0,  0,  0,      0,  6,     0,  5);
    tbl[21] = mk(1, 'h2A,  0,   0,  0,  0,      1,  'h2A,  0,  5);
    tbl[22] = mk(1, 'h2B,  0,   0,  1,  'h100,  1,  'h2B,  1,  'h2A);
    tbl[23] = mk(1, 'h100, 0,   0,  1,  'h3FF,  1,  'h100, 0,  'h2A);
    tbl[24] = mk(1, 'h3FF, 0,   0,  0,  0,      1,  'h3FF, 0,  'h2A);
    tbl[25] = mk(0, 0,     0,   1,  0,  0,      1,  0,     1,  'h3FF);
    tbl[26] = mk(0, 0,     0,   1,  0,  0,      1,  0,     1,  'h3FF);
    tbl[27] = mk(1, 0,     1,   1,  0,  0,      1,  0,     1,  'h3FF);
    tbl[28] = mk(0, 0,     0,   1,  0,  0,      0,  0,     1,  0);
    tbl[29] = mk(0, 0,     0,   1,  0,  0,      0,  0,     1,  0);
    tbl[30] = mk(0, 0,     0,   0,  0,  0,      0,  0,     1,  0);
    tbl[31] = mk(0, 0,     0,   0,  0,  0,      1,  1,     1,  0);

    rst = 1'b1; pm_ack = 1'b0; pm_data = '0; ir_take = 1'b0;
    redir = 1'b0; redir_pc = '0; hold = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check_outputs(-1, 1'b0, '0, 1'b0, '0);
    rst = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      apply(tbl[i]);
      #1;
      check_outputs(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
`ifdef VFM_IFETCH_PERF_EN
      if (i == int'(NVEC) - 1) begin
        chk("Fetch_cnt", i, 32'(fetch_cnt), 32'd9);
        chk("Stall_cnt", i, 32'(stall_cnt), 32'd11);
      end
`endif
    end

    // Asynchronous reset pulse while a request is outstanding.
    #2 rst = 1'b1;
    #1;
    check_outputs(100, 1'b0, '0, 1'b0, '0);
`ifdef VFM_IFETCH_PERF_EN
    chk("Fetch_cnt_rst", 100, 32'(fetch_cnt), 32'd0);
    chk("Stall_cnt_rst", 100, 32'(stall_cnt), 32'd0);
`endif
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_outputs(101, 1'b0, '0, 1'b0, '0);
    @(posedge clk); #2;
    check_outputs(102, 1'b1, '0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
